// File: rtl/shift_arbiter_if.sv
// Request/response bundle between two shift requesters, the arbiter and the result consumer.
interface shift_arbiter_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = 6
);
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic [SHW-1:0]   a_amt;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [SHW-1:0]   b_amt;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_src;
  logic [15:0]      op_count;

  // Requesters and consumer side
  modport master (
    output a_valid, a_data, a_amt, b_valid, b_data, b_amt, rsp_ready,
    input  a_ready, b_ready, rsp_valid, rsp_data, rsp_src, op_count
  );

  // Arbiter side
  modport slave (
    input  a_valid, a_data, a_amt, b_valid, b_data, b_amt, rsp_ready,
    output a_ready, b_ready, rsp_valid, rsp_data, rsp_src, op_count
  );
endinterface

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry left-shift result register.
module shift_arbiter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave io_bus
);
  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  localparam int unsigned CNT_W = 16;

  src_e             r_last_grant;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_src;
  logic [CNT_W-1:0] r_op_count;

  logic             w_slot_free;
  logic             w_drain;
  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_accept_a;
  logic             w_accept_b;
  logic [SHW-1:0]   w_amt_a;
  logic [SHW-1:0]   w_amt_b;
  logic [WIDTH-1:0] w_shift_a;
  logic [WIDTH-1:0] w_shift_b;

  assign w_drain     = r_rsp_valid && io_bus.rsp_ready;
  assign w_slot_free = !r_rsp_valid || io_bus.rsp_ready;

  // Grant the lone requester, or the one not served last when both ask
  always_comb begin
    w_grant_a = 1'b0;
    w_grant_b = 1'b0;
    if (io_bus.a_valid && io_bus.b_valid) begin
      if (r_last_grant == SRC_B) begin
        w_grant_a = 1'b1;
      end else begin
        w_grant_b = 1'b1;
      end
    end else if (io_bus.a_valid) begin
      w_grant_a = 1'b1;
    end else if (io_bus.b_valid) begin
      w_grant_b = 1'b1;
    end
  end

  // Reset gating keeps both readies low while rst_n is asserted
  assign w_accept_a = rst_n && w_grant_a && w_slot_free;
  assign w_accept_b = rst_n && w_grant_b && w_slot_free;

  assign w_amt_a   = io_bus.a_amt;
  assign w_amt_b   = io_bus.b_amt;
  assign w_shift_a = io_bus.a_data << w_amt_a;
  assign w_shift_b = io_bus.b_data << w_amt_b;

  // Result slot: load on accept, clear valid on a plain drain, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_src   <= 1'b0;
    end else if (w_accept_a) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_shift_a;
      r_rsp_src   <= 1'b0;
    end else if (w_accept_b) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_shift_b;
      r_rsp_src   <= 1'b1;
    end else if (w_drain) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Round-robin history; reset to B so A wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= SRC_B;
    end else if (w_accept_a) begin
      r_last_grant <= SRC_A;
    end else if (w_accept_b) begin
      r_last_grant <= SRC_B;
    end
  end

  // Saturating count of completed response transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (w_drain && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign io_bus.a_ready   = w_accept_a;
  assign io_bus.b_ready   = w_accept_b;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_data  = r_rsp_data;
  assign io_bus.rsp_src   = r_rsp_src;
  assign io_bus.op_count  = r_op_count;
endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: stimulus pushes expected results, a monitor pops and compares.
module tb_shift_arbiter;
  typedef struct packed {
    logic [63:0] data;
    logic        src;
  } exp_t;

  logic clk;
  logic rst_n;

  shift_arbiter_if #(.WIDTH(64), .SHW(6)) bus ();

  shift_arbiter #(.WIDTH(64), .SHW(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];
  int   pops     = 0;

  // Reference state: who was served last (1 = B) and whether a result occupies the slot
  logic m_last    = 1'b1;
  logic m_pending = 1'b0;
  logic acc_a     = 1'b0;
  logic acc_b     = 1'b0;

  logic        cur_av = 1'b0;
  logic [63:0] cur_ad = '0;
  logic [5:0]  cur_aa = '0;
  logic        cur_bv = 1'b0;
  logic [63:0] cur_bd = '0;
  logic [5:0]  cur_ba = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] shl(input logic [63:0] d, input logic [5:0] amt);
    logic [63:0] f;
    f = 64'd1;
    for (int i = 0; i < int'(amt); i++) f = f * 64'd2;
    return d * f;
  endfunction

  // Drive one cycle of inputs, predict acceptance from the arbitration rules, queue the result
  task automatic step(input logic av, input logic [63:0] ad, input logic [5:0] aa,
                      input logic bv, input logic [63:0] bd, input logic [5:0] ba,
                      input logic rr);
    logic ga, gb, ea, eb;
    @(negedge clk);
    bus.a_valid = av; bus.a_data = ad; bus.a_amt = aa;
    bus.b_valid = bv; bus.b_data = bd; bus.b_amt = ba;
    bus.rsp_ready = rr;
    #1;
    ga = 1'b0; gb = 1'b0;
    if (av && bv) begin
      if (m_last) ga = 1'b1; else gb = 1'b1;
    end else if (av) ga = 1'b1;
    else if (bv) gb = 1'b1;
    ea = rst_n && ga && (!m_pending || rr);
    eb = rst_n && gb && (!m_pending || rr);
    chk("a_ready", 64'(bus.a_ready), 64'(ea));
    chk("b_ready", 64'(bus.b_ready), 64'(eb));
    acc_a = ea;
    acc_b = eb;
    if (ea) begin
      q.push_back('{data: shl(ad, aa), src: 1'b0});
      m_last = 1'b0;
    end else if (eb) begin
      q.push_back('{data: shl(bd, ba), src: 1'b1});
      m_last = 1'b1;
    end
    if (ea || eb) m_pending = 1'b1;
    else if (m_pending && rr) m_pending = 1'b0;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, '0, '0, 1'b0, '0, '0, rr);
  endtask

  // Random traffic; a requester keeps its request unchanged until accepted
  task automatic rand_steps(input int n, input int pct_v, input int pct_r);
    logic rr;
    for (int k = 0; k < n; k++) begin
      if (!cur_av || acc_a) begin
        cur_av = ($urandom_range(0, 99) < pct_v);
        cur_ad = {$urandom, $urandom};
        cur_aa = 6'($urandom);
      end
      if (!cur_bv || acc_b) begin
        cur_bv = ($urandom_range(0, 99) < pct_v);
        cur_bd = {$urandom, $urandom};
        cur_ba = 6'($urandom);
      end
      rr = ($urandom_range(0, 99) < pct_r);
      step(cur_av, cur_ad, cur_aa, cur_bv, cur_bd, cur_ba, rr);
    end
  endtask

  // Half-cycle reset pulse while a result may be held
  task automatic reset_pulse();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_op_count", 64'(bus.op_count), 64'd0);
    chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
    chk("rst_b_ready", 64'(bus.b_ready), 64'd0);
    q.delete();
    pops      = 0;
    m_last    = 1'b1;
    m_pending = 1'b0;
    acc_a     = 1'b0;
    acc_b     = 1'b0;
    cur_av    = 1'b0;
    cur_bv    = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Monitor: compare presented results against the queue head, pop on transfer
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      chk("op_count", 64'(bus.op_count), 64'((pops > 65535) ? 65535 : pops));
      chk("ready_exclusive", 64'(bus.a_ready && bus.b_ready), 64'd0);
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=valid required=none t=%0t", $time);
        end else begin
          chk("rsp_data", bus.rsp_data, q[0].data);
          chk("rsp_src", 64'(bus.rsp_src), 64'(q[0].src));
          if (bus.rsp_ready) begin
            void'(q.pop_front());
            pops++;
          end else begin
            chk("stall_readies", 64'({bus.a_ready, bus.b_ready}), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.a_valid = 1'b1; bus.a_data = 64'h55; bus.a_amt = 6'd3;
    bus.b_valid = 1'b1; bus.b_data = 64'h66; bus.b_amt = 6'd2;
    bus.rsp_ready = 1'b1;
    #7;
    chk("init_a_ready", 64'(bus.a_ready), 64'd0);
    chk("init_b_ready", 64'(bus.b_ready), 64'd0);
    chk("init_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("init_rsp_data", bus.rsp_data, 64'd0);
    chk("init_rsp_src", 64'(bus.rsp_src), 64'd0);
    chk("init_op_count", 64'(bus.op_count), 64'd0);
    @(negedge clk);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    rst_n = 1'b1;

    // Single A request, shift by WIDTH-1
    step(1'b1, 64'h1, 6'd63, 1'b0, '0, '0, 1'b1);
    idle(1'b1);
    chk("msb_valid", 64'(bus.rsp_valid), 64'd1);
    chk("msb_data", bus.rsp_data, 64'h8000_0000_0000_0000);
    chk("msb_src", 64'(bus.rsp_src), 64'd0);
    idle(1'b1);
    chk("msb_count", 64'(bus.op_count), 64'd1);
    chk("drain_valid", 64'(bus.rsp_valid), 64'd0);
    chk("drain_data_hold", bus.rsp_data, 64'h8000_0000_0000_0000);

    // Hold a result, then reset mid-operation
    step(1'b0, '0, '0, 1'b1, 64'h3, 6'd1, 1'b0);
    idle(1'b0);
    chk("held_valid", 64'(bus.rsp_valid), 64'd1);
    reset_pulse();

    // Both valid after reset: A first, then strict alternation, one result per cycle
    for (int i = 0; i < 5; i++) begin
      if (i < 4) step(1'b1, 64'hF, 6'd4, 1'b1, 64'hF0, 6'd0, 1'b1);
      else idle(1'b1);
      if (i < 4) chk("alt_a_ready", 64'(bus.a_ready), 64'(i % 2 == 0));
      if (i > 0) begin
        chk("alt_valid", 64'(bus.rsp_valid), 64'd1);
        chk("alt_src", 64'(bus.rsp_src), 64'((i - 1) % 2));
        chk("alt_data", bus.rsp_data, 64'hF0);
      end
    end

    // Backpressure: result held for three cycles, then drain and accept together
    idle(1'b1);
    step(1'b1, 64'h1234, 6'd8, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, '0, 1'b1, 64'h5, 6'd1, 1'b0);
      chk("stall_data", bus.rsp_data, 64'h12_3400);
      chk("stall_b_ready", 64'(bus.b_ready), 64'd0);
    end
    step(1'b0, '0, '0, 1'b1, 64'h5, 6'd1, 1'b1);
    chk("swap_b_ready", 64'(bus.b_ready), 64'd1);

    // Zero shift passes data through, accepted in the same cycle as the drain
    step(1'b1, 64'hDEAD_BEEF_0123_4567, 6'd0, 1'b0, '0, '0, 1'b1);
    chk("nobubble_valid", 64'(bus.rsp_valid), 64'd1);
    chk("nobubble_src", 64'(bus.rsp_src), 64'd1);
    chk("nobubble_data", bus.rsp_data, 64'hA);
    idle(1'b1);
    chk("pass_data", bus.rsp_data, 64'hDEAD_BEEF_0123_4567);
    chk("pass_src", 64'(bus.rsp_src), 64'd0);

    // Randomized mixed traffic with backpressure
    rand_steps(600, 70, 60);

    // Continuous traffic past the counter limit
    rand_steps(65540, 100, 100);
    idle(1'b1);
    idle(1'b1);
    chk("sat_count", 64'(bus.op_count), 64'hFFFF);

    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the operand/result width in bits.
REQ-002 Parameter SHW, default 6, SHALL set the shift-amount width; WIDTH SHALL equal 2**SHW.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 a_valid / b_valid  input  1  SHALL flag a pending request from requester A / B.
REQ-006 a_ready / b_ready  output  1  SHALL flag acceptance of the corresponding request this cycle.
REQ-007 a_data / b_data  input  WIDTH  SHALL be the operand to shift.
REQ-008 a_amt / b_amt  input  SHW  SHALL be the left-shift amount.
REQ-009 rsp_valid  output  1  SHALL flag that rsp_data and rsp_src hold a valid result.
REQ-010 rsp_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-011 rsp_data  output  WIDTH  SHALL be the shifted result.
REQ-012 rsp_src  output  1  SHALL identify the requester that produced the result (0 = A, 1 = B).
REQ-013 op_count  output  16  SHALL count the number of completed response transfers.

Function
REQ-014 A transfer on a port SHALL occur when valid and ready are both high on the same rising edge.
REQ-015 A requester SHALL hold valid, data and amt stable until its transfer occurs.
REQ-016 slot_free SHALL be (!rsp_valid || rsp_ready).
REQ-017 The grant SHALL go to the only valid requester, or to the requester not named by last_grant when both are valid, or to none when neither is valid.
REQ-018 a_ready SHALL equal (grant==A && slot_free), b_ready SHALL equal (grant==B && slot_free), and the two SHALL never be high together.
REQ-019 last_grant SHALL update to the accepted requester only on an accepted transfer; otherwise it SHALL hold.
REQ-020 On acceptance, rsp_data SHALL load (data << amt) truncated to WIDTH bits with zero fill, rsp_src SHALL load the requester id, and rsp_valid SHALL be 1 on the next cycle, giving a latency of exactly 1 cycle.
REQ-021 An amt of 0 SHALL pass the data through unchanged; an amt of WIDTH-1 SHALL leave only data[0] at the MSB.
REQ-022 On a simultaneous drain and accept (rsp_valid && rsp_ready && new accept), the new result SHALL replace the old one, rsp_valid SHALL stay 1, and there SHALL be no bubble.
REQ-023 On a drain without accept, rsp_valid SHALL drop to 0 and rsp_data/rsp_src SHALL hold their last values.
REQ-024 While rsp_valid && !rsp_ready, rsp_data and rsp_src SHALL hold stable and both ready outputs SHALL be 0.
REQ-025 op_count SHALL increment on each rsp_valid && rsp_ready, SHALL saturate at 16'hFFFF, and SHALL NOT wrap.
REQ-026 The ready outputs SHALL be combinational from the valids, last_grant, rsp_valid and rsp_ready; there SHALL be no combinational path from data or amt to any output.
REQ-027 With both requesters continuously valid and rsp_ready held at 1, grants SHALL alternate A,B,A,B with a throughput of 1 result per cycle.

Reset
REQ-028 Asserting rst_n low SHALL immediately force rsp_valid=0, rsp_data=0, rsp_src=0, op_count=0, and last_grant=B (A preferred first).
REQ-029 While rst_n is low, a_ready and b_ready SHALL be 0.
REQ-030 A reset asserted mid-operation SHALL discard any held result without issuing a response, and the first request after deassertion SHALL behave as the first request after power-up.
REQ-031 Deassertion of rst_n SHALL be synchronized externally; the block SHALL accept requests from the first rising edge with rst_n high.

Verification
REQ-032 Reset, then a_valid=1, a_data=64'h1, a_amt=6'd63, rsp_ready=1 -> on the next cycle rsp_valid=1, rsp_data=64'h8000_0000_0000_0000, rsp_src=0; op_count=1 one cycle later.
REQ-033 Both valid for 4 cycles with rsp_ready=1, a_data=64'hF, b_data=64'hF0, amts 4 and 0 -> rsp_src sequence 0,1,0,1 and rsp_data=64'hF0 each cycle.
REQ-034 Hold rsp_ready=0 for 3 cycles with a result held -> rsp_data stable, a_ready=b_ready=0; raise rsp_ready with b_valid high -> drain and accept in the same cycle, no bubble.
REQ-035 Drive a_amt=0 with a_data=64'hDEAD_BEEF_0123_4567 -> rsp_data equals the input unchanged.
REQ-036 Accept a request, then pulse rst_n low for half a cycle while rsp_valid=1 -> rsp_valid=0 and op_count=0 immediately; the next request with both valid is granted to A.
REQ-037 Preload 65535 transfers (or use a forced counter) and perform 2 more -> op_count=16'hFFFF.
